mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have no parameters; memory geometry is fixed at 32 words x 32 bits, 5-bit word address.
REQ-002 The block SHALL have one clock, Clock; reset is asynchronous and active-low, port R.
REQ-003 Clock  in  1  rising-edge clock shared with the data memory.
REQ-004 R  in  1  asynchronous active-low reset.
REQ-005 InValid  in  1  request valid from execute stage.
REQ-006 InReady  out  1  stage can accept a request this cycle.
REQ-007 InWrite  in  1  1 = store, 0 = load.
REQ-008 InSize  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 InSigned  in  1  sign-extend sub-word loads.
REQ-010 InAddr  in  7  byte address; [6:2] word index, [1:0] byte offset.
REQ-011 InData  in  32  store data; sub-word data right-aligned.
REQ-012 InRd  in  5  destination register tag, passed through.
REQ-013 MemWriteEn  out  1  word write enable to data memory.
REQ-014 MemAddy  out  5  data memory word address.
REQ-015 MemWriteData  out  32  data memory write word.
REQ-016 MemReadData  in  32  data memory combinational read word.
REQ-017 OutValid  out  1  result valid to writeback.
REQ-018 OutReady  in  1  writeback accepts result.
REQ-019 OutData  out  32  load result; 0 for stores and faults.
REQ-020 OutRd  out  5  registered InRd.
REQ-021 OutRegWrite  out  1  1 only for a completed, aligned load.
REQ-022 OutMisaligned  out  1  request was misaligned; no memory access performed.

Function
REQ-023 States SHALL be IDLE, ACCESS, WRITE, DONE; InReady=1 only in IDLE.
REQ-024 IDLE: InValid&InReady SHALL latch InWrite/InSize/InSigned/InAddr/InData/InRd into request registers and go to ACCESS.
REQ-025 MemAddy SHALL equal latched InAddr[6:2] in ACCESS and WRITE, and 0 otherwise.
REQ-026 Misalignment SHALL be: half with addr[0]=1, or word with addr[1:0]!=0; byte requests are never misaligned.
REQ-027 ACCESS, misaligned: MemWriteEn=0, OutData=0, OutRegWrite=0, OutMisaligned=1; go to DONE.
REQ-028 ACCESS, load: select lane from MemReadData (little-endian: byte k = bits [8k+7:8k], half at offset 0 = [15:0], offset 2 = [31:16]), zero- or sign-extend per InSigned, register into OutData, OutRegWrite=1; go to DONE.
REQ-029 ACCESS, word store: MemWriteEn=1 and MemWriteData=latched data for exactly that cycle; go to DONE.
REQ-030 ACCESS, byte/half store: merge store data into the selected lane of MemReadData, register the merged word, and do not write; go to WRITE.
REQ-031 WRITE: MemWriteEn=1 and MemWriteData=merged word for exactly one cycle; go to DONE.
REQ-032 DONE: OutValid=1 with OutData/OutRd/OutRegWrite/OutMisaligned held stable; go to IDLE on OutReady, otherwise hold indefinitely.
REQ-033 Latency from accept to OutValid SHALL be 2 cycles for loads, word stores, and faults, and 3 cycles for sub-word stores.
REQ-034 MemWriteEn SHALL be decoded combinationally from state only and never asserted in IDLE or DONE.
REQ-035 Stores SHALL complete with OutValid=1, OutRegWrite=0, OutData=0.

Reset
REQ-036 While R=0, the block SHALL force state=IDLE immediately and clear all request and output registers.
REQ-037 During reset, outputs SHALL be: OutValid=0, OutData=0, OutRd=0, OutRegWrite=0, OutMisaligned=0, MemWriteEn=0, MemAddy=0, MemWriteData=0, InReady=0.
REQ-038 Reset asserted in WRITE or ACCESS SHALL abort the operation with no memory write, and the aborted request SHALL not be replayed.
REQ-039 After R rises, InReady SHALL be 1 from the first clock edge.

Verification
REQ-040 Word store addr 0x0C, data 0xDEADBEEF -> one MemWriteEn pulse, MemAddy=3; a later word load of 0x0C returns OutData=0xDEADBEEF, OutRegWrite=1.
REQ-041 Byte store 0xA5 to 0x0D over word 0xDEADBEEF -> single MemWriteEn in WRITE, MemWriteData=0xDEADA5EF, OutValid 3 cycles after accept.
REQ-042 Byte load 0x0D from word 0xDEADA5EF -> signed gives 0xFFFFFFA5, unsigned gives 0x000000A5.
REQ-043 Half load 0x0F -> OutMisaligned=1, OutData=0, OutRegWrite=0, no MemWriteEn; half store 0x0F leaves memory unchanged.
REQ-044 OutReady=0 for 3 cycles in DONE -> OutValid and all Out* stable, InReady=0; the stage accepts a new request the cycle after OutReady=1.
REQ-045 R=0 asserted in WRITE -> MemWriteEn drops immediately, memory word unchanged, all outputs 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: one request at a time against a 32x32 data memory.
// Sub-word stores read-merge-write the addressed word over two memory cycles.
module mem_access_stage (
   input  logic        Clock,
   input  logic        R,
   input  logic        InValid,
   output logic        InReady,
   input  logic        InWrite,
   input  logic [1:0]  InSize,
   input  logic        InSigned,
   input  logic [6:0]  InAddr,
   input  logic [31:0] InData,
   input  logic [4:0]  InRd,
   output logic        MemWriteEn,
   output logic [4:0]  MemAddy,
   output logic [31:0] MemWriteData,
   input  logic [31:0] MemReadData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] OutData,
   output logic [4:0]  OutRd,
   output logic        OutRegWrite,
   output logic        OutMisaligned
);

   typedef enum logic [1:0] {StIdle, StAccess, StWrite, StDone} state_e;

   state_e      state_q, state_d;
   logic        req_write_q;
   logic [1:0]  req_size_q;
   logic        req_signed_q;
   logic [6:0]  req_addr_q;
   logic [31:0] req_data_q;
   logic [4:0]  req_rd_q;
   logic [31:0] merged_q, merged_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_reg_write_q, out_reg_write_d;
   logic        out_mis_q, out_mis_d;

   logic        accept;
   logic        is_byte, is_half, is_word, misaligned;
   logic [4:0]  lane_shift;
   logic [31:0] shifted, load_val, lane_mask, lane_data, merged;

   assign InReady = (state_q == StIdle) & R;
   assign accept  = InValid & InReady;

   // Lane extraction and store merge against the currently addressed word
   always_comb begin
      is_byte    = (req_size_q == 2'b00);
      is_half    = (req_size_q == 2'b01);
      is_word    = req_size_q[1];
      misaligned = (is_half & req_addr_q[0]) | (is_word & (req_addr_q[1:0] != 2'b00));
      lane_shift = {req_addr_q[1:0], 3'b000};
      shifted    = MemReadData >> lane_shift;
      if (is_byte) begin
         load_val = {{24{req_signed_q & shifted[7]}}, shifted[7:0]};
      end else if (is_half) begin
         load_val = {{16{req_signed_q & shifted[15]}}, shifted[15:0]};
      end else begin
         load_val = MemReadData;
      end
      lane_mask = (is_byte ? 32'h0000_00ff : 32'h0000_ffff) << lane_shift;
      lane_data = (req_data_q & (is_byte ? 32'h0000_00ff : 32'h0000_ffff)) << lane_shift;
      merged    = (MemReadData & ~lane_mask) | lane_data;
   end

   always_comb begin
      state_d         = state_q;
      merged_d        = merged_q;
      out_data_d      = out_data_q;
      out_reg_write_d = out_reg_write_q;
      out_mis_d       = out_mis_q;
      MemWriteEn      = 1'b0;
      MemWriteData    = 32'h0;
      MemAddy         = 5'h0;
      OutValid        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StAccess;
         end
         StAccess: begin
            MemAddy         = req_addr_q[6:2];
            out_data_d      = 32'h0;
            out_reg_write_d = 1'b0;
            out_mis_d       = 1'b0;
            state_d         = StDone;
            if (misaligned) begin
               out_mis_d = 1'b1;
            end else if (!req_write_q) begin
               out_data_d      = load_val;
               out_reg_write_d = 1'b1;
            end else if (is_word) begin
               MemWriteEn   = 1'b1;
               MemWriteData = req_data_q;
            end else begin
               merged_d = merged;
               state_d  = StWrite;
            end
         end
         StWrite: begin
            MemAddy      = req_addr_q[6:2];
            MemWriteEn   = 1'b1;
            MemWriteData = merged_q;
            state_d      = StDone;
         end
         StDone: begin
            OutValid = 1'b1;
            if (OutReady) state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge R) begin
      if (!R) begin
         state_q         <= StIdle;
         req_write_q     <= 1'b0;
         req_size_q      <= 2'b00;
         req_signed_q    <= 1'b0;
         req_addr_q      <= 7'h0;
         req_data_q      <= 32'h0;
         req_rd_q        <= 5'h0;
         merged_q        <= 32'h0;
         out_data_q      <= 32'h0;
         out_reg_write_q <= 1'b0;
         out_mis_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         merged_q        <= merged_d;
         out_data_q      <= out_data_d;
         out_reg_write_q <= out_reg_write_d;
         out_mis_q       <= out_mis_d;
         if (accept) begin
            req_write_q  <= InWrite;
            req_size_q   <= InSize;
            req_signed_q <= InSigned;
            req_addr_q   <= InAddr;
            req_data_q   <= InData;
            req_rd_q     <= InRd;
         end
      end
   end

   assign OutData       = out_data_q;
   assign OutRd         = req_rd_q;
   assign OutRegWrite   = out_reg_write_q;
   assign OutMisaligned = out_mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: behavioural data memory, reference memory model and
// a scoreboard of expected completions.
module tb_mem_access_stage;

   logic        Clock = 1'b0;
   logic        R;
   logic        InValid, InReady, InWrite, InSigned;
   logic [1:0]  InSize;
   logic [6:0]  InAddr;
   logic [31:0] InData;
   logic [4:0]  InRd;
   logic        MemWriteEn;
   logic [4:0]  MemAddy;
   logic [31:0] MemWriteData, MemReadData;
   logic        OutValid, OutReady, OutRegWrite, OutMisaligned;
   logic [31:0] OutData;
   logic [4:0]  OutRd;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        regw;
      logic        mis;
      int          lat;
      int          nwr;
      logic [31:0] wdata;
      logic [4:0]  waddr;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem [32] = '{default: 32'h0};
   logic [31:0] ref_mem [32] = '{default: 32'h0};
   int          wr_count = 0;
   logic [31:0] last_wdata = 32'h0;
   logic [4:0]  last_waddr = 5'h0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 Clock = ~Clock;

   mem_access_stage dut (
      .Clock(Clock), .R(R), .InValid(InValid), .InReady(InReady), .InWrite(InWrite),
      .InSize(InSize), .InSigned(InSigned), .InAddr(InAddr), .InData(InData), .InRd(InRd),
      .MemWriteEn(MemWriteEn), .MemAddy(MemAddy), .MemWriteData(MemWriteData),
      .MemReadData(MemReadData), .OutValid(OutValid), .OutReady(OutReady),
      .OutData(OutData), .OutRd(OutRd), .OutRegWrite(OutRegWrite),
      .OutMisaligned(OutMisaligned)
   );

   assign MemReadData = mem[MemAddy];

   always @(posedge Clock) begin
      if (MemWriteEn) begin
         mem[MemAddy] <= MemWriteData;
         wr_count     <= wr_count + 1;
         last_wdata   <= MemWriteData;
         last_waddr   <= MemAddy;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: computes the completion and updates ref_mem for stores
   task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [6:0] a, input logic [31:0] d, input logic [4:0] rd,
                        output exp_t e);
      logic [31:0] word, nw;
      logic [7:0]  b;
      logic [15:0] h;
      int          off;
      off     = int'(a[1:0]);
      word    = ref_mem[a[6:2]];
      e.rd    = rd;
      e.data  = 32'h0;
      e.regw  = 1'b0;
      e.lat   = 2;
      e.nwr   = 0;
      e.wdata = 32'h0;
      e.waddr = a[6:2];
      e.mis   = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
      if (e.mis) return;
      if (!w) begin
         e.regw = 1'b1;
         if (sz == 2'b00) begin
            b      = word[8*off +: 8];
            e.data = sg ? {{24{b[7]}}, b} : {24'h0, b};
         end else if (sz == 2'b01) begin
            h      = a[1] ? word[31:16] : word[15:0];
            e.data = sg ? {{16{h[15]}}, h} : {16'h0, h};
         end else begin
            e.data = word;
         end
      end else begin
         e.nwr = 1;
         if (sz[1]) begin
            nw = d;
         end else begin
            nw    = word;
            e.lat = 3;
            for (int i = 0; i < 4; i++) begin
               if (i == off || (sz == 2'b01 && i == off + 1)) nw[8*i +: 8] = d[8*(i-off) +: 8];
            end
         end
         e.wdata          = nw;
         ref_mem[a[6:2]]  = nw;
      end
   endtask

   task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [6:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input int hold);
      exp_t        e, m;
      int          wr0, cyc, n;
      logic [31:0] od;
      logic [4:0]  ord;
      logic        orw, omis;
      model(w, sz, sg, a, d, rd, m);
      sb.push_back(m);
      @(negedge Clock);
      OutReady = (hold == 0);
      InValid  = 1'b1;
      InWrite  = w;
      InSize   = sz;
      InSigned = sg;
      InAddr   = a;
      InData   = d;
      InRd     = rd;
      n = 0;
      while (!InReady && n < 20) begin
         @(negedge Clock);
         n++;
      end
      check_eq("in_ready", 32'(InReady), 32'd1);
      wr0 = wr_count;
      @(posedge Clock);
      @(negedge Clock);
      InValid = 1'b0;
      cyc = 1;
      while (!OutValid && cyc < 20) begin
         @(negedge Clock);
         cyc++;
      end
      e = sb.pop_front();
      check_eq("out_valid", 32'(OutValid), 32'd1);
      check_eq("latency", 32'(cyc), 32'(e.lat));
      check_eq("out_data", OutData, e.data);
      check_eq("out_rd", 32'(OutRd), 32'(e.rd));
      check_eq("out_reg_write", 32'(OutRegWrite), 32'(e.regw));
      check_eq("out_misaligned", 32'(OutMisaligned), 32'(e.mis));
      check_eq("write_pulses", 32'(wr_count - wr0), 32'(e.nwr));
      check_eq("in_ready_done", 32'(InReady), 32'd0);
      if (e.nwr > 0) begin
         check_eq("write_data", last_wdata, e.wdata);
         check_eq("write_addr", 32'(last_waddr), 32'(e.waddr));
      end
      if (hold > 0) begin
         od = OutData; ord = OutRd; orw = OutRegWrite; omis = OutMisaligned;
         for (int i = 0; i < hold; i++) begin
            @(negedge Clock);
            check_eq("hold_valid", 32'(OutValid), 32'd1);
            check_eq("hold_ready", 32'(InReady), 32'd0);
            check_eq("hold_data", OutData, od);
            check_eq("hold_rd", 32'(OutRd), 32'(ord));
            check_eq("hold_regw", 32'({OutRegWrite, OutMisaligned}), 32'({orw, omis}));
         end
         OutReady = 1'b1;
         @(negedge Clock);
         check_eq("release_ready", 32'(InReady), 32'd1);
         check_eq("release_valid", 32'(OutValid), 32'd0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_out"}, {OutData[31:0]} | 32'({OutValid, OutRd, OutRegWrite, OutMisaligned}),
               32'h0);
      check_eq({tag, "_mem"}, MemWriteData | 32'({MemWriteEn, MemAddy}), 32'h0);
      check_eq({tag, "_in_ready"}, 32'(InReady), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      logic [31:0] keep;
      R = 1'b0; InValid = 1'b0; InWrite = 1'b0; InSize = 2'b00; InSigned = 1'b0;
      InAddr = 7'h0; InData = 32'h0; InRd = 5'h0; OutReady = 1'b1;
      #2;
      check_all_zero("reset0");
      repeat (2) @(negedge Clock);
      check_all_zero("reset1");
      R = 1'b1;
      @(negedge Clock);
      check_eq("ready_after_reset", 32'(InReady), 32'd1);

      run_req(1'b1, 2'b10, 1'b0, 7'h0c, 32'hdeadbeef, 5'd1, 0);
      check_eq("mem3_word", mem[3], 32'hdeadbeef);
      run_req(1'b0, 2'b10, 1'b0, 7'h0c, 32'h0, 5'd2, 0);
      run_req(1'b1, 2'b00, 1'b0, 7'h0d, 32'h000000a5, 5'd3, 0);
      check_eq("mem3_byte", mem[3], 32'hdeada5ef);
      run_req(1'b0, 2'b00, 1'b1, 7'h0d, 32'h0, 5'd4, 0);
      run_req(1'b0, 2'b00, 1'b0, 7'h0d, 32'h0, 5'd5, 0);
      run_req(1'b0, 2'b01, 1'b0, 7'h0f, 32'h0, 5'd6, 0);
      run_req(1'b1, 2'b01, 1'b0, 7'h0f, 32'h1234, 5'd7, 0);
      check_eq("mem3_unchanged", mem[3], 32'hdeada5ef);
      run_req(1'b1, 2'b01, 1'b0, 7'h12, 32'h12348001, 5'd8, 0);
      run_req(1'b0, 2'b01, 1'b1, 7'h12, 32'h0, 5'd9, 0);
      run_req(1'b0, 2'b01, 1'b0, 7'h10, 32'h0, 5'd10, 0);
      run_req(1'b0, 2'b11, 1'b0, 7'h0c, 32'h0, 5'd11, 0);
      run_req(1'b0, 2'b10, 1'b0, 7'h0e, 32'h0, 5'd12, 0);
      run_req(1'b0, 2'b10, 1'b0, 7'h0c, 32'h0, 5'd13, 3);
      run_req(1'b0, 2'b00, 1'b1, 7'h0d, 32'h0, 5'd14, 0);

      for (int i = 0; i < 40; i++) begin
         run_req(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                 7'($urandom_range(127)), $urandom, 5'($urandom_range(31)), 0);
      end
      for (int i = 0; i < 32; i++) check_eq("mem_final", mem[i], ref_mem[i]);

      // Abort a byte store while it is in WRITE
      keep = mem[3];
      wr0  = wr_count;
      @(negedge Clock);
      InValid = 1'b1; InWrite = 1'b1; InSize = 2'b00; InSigned = 1'b0;
      InAddr = 7'h0d; InData = 32'h77; InRd = 5'd21;
      @(posedge Clock);
      @(negedge Clock);
      InValid = 1'b0;
      @(negedge Clock);
      check_eq("abort_in_write", 32'(MemWriteEn), 32'd1);
      R = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (2) @(negedge Clock);
      R = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         check_eq("no_replay", 32'({OutValid, MemWriteEn}), 32'd0);
      end
      check_eq("abort_ready", 32'(InReady), 32'd1);
      check_eq("abort_mem", mem[3], keep);
      check_eq("abort_writes", 32'(wr_count - wr0), 32'd0);
      run_req(1'b0, 2'b10, 1'b0, 7'h0c, 32'h0, 5'd22, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
